// File: rtl/square16_serial_pkg.sv
`default_nettype none
// ============================================================================
// square16_serial_pkg
// Q6.10 widths and FSM state encodings for square16_serial.
// Revision: 1.0
// ============================================================================
package square16_serial_pkg;

    localparam int c_DATA_W = 16;
    localparam int c_FRAC_W = 10;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_MUL   = 2'd1;
    localparam logic [1:0] c_S_SCALE = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/square16_serial.sv
`default_nettype none
// ============================================================================
// square16_serial
// Serial shift-add square of a signed Q6.10 value, saturating to 0x7FFF.
// Build option: SQUARE16_ROUND_EN selects round-half-up instead of truncation.
// Revision: 1.0
// ============================================================================
module square16_serial
    import square16_serial_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int FRAC_W = c_FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y,
    output logic              ovf,
    output logic              busy
);

    localparam int                  c_ACC_W    = 2 * DATA_W;
    localparam int                  c_CNT_W    = $clog2(DATA_W);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0]   c_Q_MAX    = {1'b0, {(DATA_W-1){1'b1}}};

    logic [1:0]         r_state;
    logic [c_ACC_W-1:0] r_acc;
    logic [DATA_W-1:0]  r_mcand;
    logic [DATA_W-1:0]  r_mplr;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_y;
    logic               r_ovf;
    logic               r_out_valid;

    logic [DATA_W-1:0]  w_mag;
    logic [c_ACC_W-1:0] w_pp;
    logic [c_ACC_W-1:0] w_scaled;
    logic [DATA_W-1:0]  w_r;
    logic               w_ovf;
    logic [FRAC_W-1:0]  w_unused_frac;

    // Most negative input wraps to 0x8000, which is its true magnitude as unsigned.
    assign w_mag = x[DATA_W-1] ? (~x + 1'b1) : x;
    assign w_pp  = {{DATA_W{1'b0}}, r_mcand} << r_cnt;

`ifdef SQUARE16_ROUND_EN
    localparam logic [c_ACC_W-1:0] c_HALF = c_ACC_W'(1) << (FRAC_W - 1);
    assign w_scaled = r_acc + c_HALF;
`else
    assign w_scaled = r_acc;
`endif

    // Any set bit at or above the result sign position cannot be represented.
    assign w_ovf         = |w_scaled[c_ACC_W-1:DATA_W+FRAC_W-1];
    assign w_r           = w_scaled[DATA_W+FRAC_W-1:FRAC_W];
    assign w_unused_frac = w_scaled[FRAC_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_S_IDLE;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplr      <= '0;
            r_cnt       <= '0;
            r_y         <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (in_valid) begin
                        r_mcand <= w_mag;
                        r_mplr  <= w_mag;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= c_S_MUL;
                    end
                end
                c_S_MUL: begin
                    if (r_mplr[r_cnt]) begin
                        r_acc <= r_acc + w_pp;
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_S_SCALE;
                    end
                end
                c_S_SCALE: begin
                    r_y         <= w_ovf ? c_Q_MAX : w_r;
                    r_ovf       <= w_ovf;
                    r_out_valid <= 1'b1;
                    r_state     <= c_S_DONE;
                end
                c_S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_S_IDLE) && rst;
    assign busy      = (r_state != c_S_IDLE);
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_square16_serial.sv
`default_nettype none
// ============================================================================
// tb_square16_serial
// Self-checking bench: directed table, backpressure, mid-operation reset,
// and a randomized full-throughput stream against an arithmetic model.
// Revision: 1.0
// ============================================================================
module tb_square16_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] y;
    logic        ovf;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    localparam int c_N_RAND = 2000;

    square16_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: exact integer square, scaled by 2^-10, clamped to the positive range.
    function automatic logic [16:0] ref_sq(input logic [15:0] xv);
        longint v;
        longint p;
        v = longint'($signed(xv));
        p = v * v;
`ifdef SQUARE16_ROUND_EN
        p = p + 512;
`endif
        p = p / 1024;
        if (p > 32767) return {1'b1, 16'h7FFF};
        return {1'b0, p[15:0]};
    endfunction

    function automatic logic [15:0] rand_x();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 3))
            0: v = {{6{v[15]}}, v[9:0]};
            1: begin
                v = 16'(5780 + $urandom_range(0, 25));
                if ($urandom_range(0, 1) == 1) v = -v;
            end
            default: ;
        endcase
        return v;
    endfunction

    task automatic do_txn(input logic [15:0] xv, output logic [15:0] yv,
                          output logic ov, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b1;
        x        = xv;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        yv = y;
        ov = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t        tbl[9];
        logic [15:0] ry;
        logic        rov;
        int          lat;
        logic [16:0] q[$];
        logic [16:0] e;
        int          n_in;
        int          n_out;
        int          cycles;
        logic        acc_hs;
        logic        out_hs;

        tbl[0] = '{16'h0400, 16'h0400, 1'b0};
        tbl[1] = '{16'h0800, 16'h1000, 1'b0};
        tbl[2] = '{16'hFE00, 16'h0100, 1'b0};
        tbl[3] = '{16'h0000, 16'h0000, 1'b0};
        tbl[4] = '{16'h1000, 16'h4000, 1'b0};
        tbl[5] = '{16'h8000, 16'h7FFF, 1'b1};
        tbl[6] = '{16'h16A1, 16'h7FFF, 1'b1};
`ifdef SQUARE16_ROUND_EN
        tbl[7] = '{16'h0017, 16'h0001, 1'b0};
`else
        tbl[7] = '{16'h0017, 16'h0000, 1'b0};
`endif
        tbl[8] = '{16'h0001, 16'h0000, 1'b0};

        // Reset state
        #23;
        check("reset_y", 32'(y), 32'h0);
        check("reset_ovf", 32'(ovf), 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(in_ready), 32'h1);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            do_txn(tbl[i].x, ry, rov, lat);
            check($sformatf("tbl%0d_y", i), 32'(ry), 32'(tbl[i].y));
            check($sformatf("tbl%0d_ovf", i), 32'(rov), 32'(tbl[i].ovf));
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd17);
        end

        // Backpressure: result held, new requests ignored
        in_valid = 1'b1;
        x        = 16'h0800;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd17);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            x        = 16'h1234;
            check($sformatf("bp_hold%0d", i), {14'h0, out_valid, in_ready, y}, {14'h0, 1'b1, 1'b0, 16'h1000});
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release", {29'h0, out_valid, in_ready, busy}, {29'h0, 1'b0, 1'b1, 1'b0});

        // Reset during MUL
        in_valid = 1'b1;
        x        = 16'h0C00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'h0);
        check("midreset_y", 32'(y), 32'h0);
        check("midreset_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midreset_no_partial", {30'h0, out_valid, busy}, 32'h0);
        do_txn(16'h0C00, ry, rov, lat);
        check("after_reset_y", 32'(ry), 32'h2400);
        check("after_reset_lat", 32'(lat), 32'd17);

        // Random stream at full throughput
        n_in      = 0;
        n_out     = 0;
        cycles    = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x         = rand_x();
        while (n_out < c_N_RAND && cycles < c_N_RAND * 19 + 200) begin
            acc_hs = in_valid && in_ready;
            out_hs = out_valid && out_ready;
            if (out_hs) begin
                if (q.size() == 0) begin
                    check("rand_unexpected_output", 32'(y), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    check("rand_result", {15'h0, ovf, y}, {15'h0, e});
                end
                n_out++;
            end
            @(posedge clk); #1;
            cycles++;
            if (acc_hs) begin
                q.push_back(ref_sq(x));
                n_in++;
                if (n_in < c_N_RAND) x = rand_x();
                else in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rand_count", 32'(n_out), 32'(c_N_RAND));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
